// File: rtl/btb_ctx_bank.sv
// Multi-context branch target buffer: NR_CTX independent BTB images, predictions from the
// active context, one-deep update stage, and a row-per-cycle context clone engine.
module btb_ctx_bank #(
   parameter int NR_CTX          = 4,
   parameter int NR_ENTRIES      = 8,
   parameter int INSTR_PER_FETCH = 2,
   parameter int VLEN            = 39,
   localparam int CTX_W          = $clog2(NR_CTX),
   localparam int ROW_W          = $clog2(NR_ENTRIES),
   localparam int COL_W          = $clog2(INSTR_PER_FETCH)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic                              debug_mode_i,
   input  logic [CTX_W-1:0]                  ctx_sel_i,
   output logic [CTX_W-1:0]                  active_ctx_o,
   input  logic [VLEN-1:0]                   vpc_i,
   input  logic                              upd_valid_i,
   input  logic [VLEN-1:0]                   upd_pc_i,
   input  logic [VLEN-1:0]                   upd_target_i,
   output logic [INSTR_PER_FETCH-1:0]        pred_valid_o,
   output logic [INSTR_PER_FETCH*VLEN-1:0]   pred_target_o,
   input  logic                              clone_req_i,
   input  logic [CTX_W-1:0]                  clone_src_i,
   input  logic [CTX_W-1:0]                  clone_dst_i,
   output logic                              clone_busy_o,
   output logic                              clone_done_o,
   output logic                              clone_err_o
);

   // Handshake: clone_req_i is sampled only in IDLE; an accepted request is acknowledged by
   // clone_busy_o on the following cycle, a rejected one by clone_err_o in the same cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COPY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [ROW_W-1:0]      r_cnt;
   logic [ROW_W-1:0]      w_cnt_nxt;
   logic [CTX_W-1:0]      r_src;
   logic [CTX_W-1:0]      r_dst;
   logic                  w_start;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_err;

   logic [CTX_W-1:0]      r_active_ctx;
   logic                  r_stg_valid;
   logic [CTX_W-1:0]      r_stg_ctx;
   logic [ROW_W-1:0]      r_stg_row;
   logic [COL_W-1:0]      r_stg_col;
   logic [VLEN-1:0]       r_stg_tgt;

   logic                  r_valid  [NR_CTX][NR_ENTRIES][INSTR_PER_FETCH];
   logic [VLEN-1:0]       r_target [NR_CTX][NR_ENTRIES][INSTR_PER_FETCH];

   logic [ROW_W-1:0]      w_vpc_row;
   logic [ROW_W-1:0]      w_upd_row;
   logic [COL_W-1:0]      w_upd_col;
   logic                  w_sel_ok;
   logic                  w_src_ok;
   logic                  w_dst_ok;
   logic                  w_clone_legal;
   logic                  w_upd_take;
   logic                  w_unused;

   assign w_vpc_row = vpc_i[ROW_W+COL_W:COL_W+1];
   assign w_upd_row = upd_pc_i[ROW_W+COL_W:COL_W+1];
   assign w_upd_col = upd_pc_i[COL_W:1];
   assign w_unused  = ^{vpc_i[VLEN-1:ROW_W+COL_W+1], vpc_i[COL_W:0],
                        upd_pc_i[VLEN-1:ROW_W+COL_W+1], upd_pc_i[0]};

   // Context ids can only be out of range when NR_CTX is not a power of two.
   if ((1 << CTX_W) == NR_CTX) begin : g_ctx_pow2
      assign w_sel_ok = 1'b1;
      assign w_src_ok = 1'b1;
      assign w_dst_ok = 1'b1;
   end else begin : g_ctx_npow2
      assign w_sel_ok = (32'(ctx_sel_i)   < 32'(NR_CTX));
      assign w_src_ok = (32'(clone_src_i) < 32'(NR_CTX));
      assign w_dst_ok = (32'(clone_dst_i) < 32'(NR_CTX));
   end

   assign w_clone_legal = (clone_src_i != clone_dst_i) && w_src_ok && w_dst_ok;
   assign w_upd_take    = upd_valid_i && !debug_mode_i && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_active_ctx <= '0;
      end else if (w_sel_ok) begin
         r_active_ctx <= ctx_sel_i;
      end
   end

   // The stage records the context active at capture, so a later switch cannot redirect it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stg_valid <= 1'b0;
         r_stg_ctx   <= '0;
         r_stg_row   <= '0;
         r_stg_col   <= '0;
         r_stg_tgt   <= '0;
      end else begin
         r_stg_valid <= w_upd_take;
         if (w_upd_take) begin
            r_stg_ctx <= r_active_ctx;
            r_stg_row <= w_upd_row;
            r_stg_col <= w_upd_col;
            r_stg_tgt <= upd_target_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_src   <= '0;
         r_dst   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_start) begin
            r_src <= clone_src_i;
            r_dst <= clone_dst_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clone_req_i) begin
               if (w_clone_legal) begin
                  w_start     = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_COPY;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         S_COPY: begin
            w_busy    = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == ROW_W'(NR_ENTRIES - 1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (flush_i) begin
         w_state_nxt = S_IDLE;
         w_start     = 1'b0;
      end
   end

   // Copy first, stage write second: the stage wins on a shared destination, and the copy
   // reads the pre-edge array so a same-cycle write to the source is not propagated.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NR_CTX; c++) begin
            for (int r = 0; r < NR_ENTRIES; r++) begin
               for (int k = 0; k < INSTR_PER_FETCH; k++) begin
                  r_valid[c][r][k]  <= 1'b0;
                  r_target[c][r][k] <= '0;
               end
            end
         end
      end else if (flush_i) begin
         for (int c = 0; c < NR_CTX; c++) begin
            for (int r = 0; r < NR_ENTRIES; r++) begin
               for (int k = 0; k < INSTR_PER_FETCH; k++) begin
                  r_valid[c][r][k] <= 1'b0;
               end
            end
         end
      end else begin
         if (r_state == S_COPY) begin
            for (int k = 0; k < INSTR_PER_FETCH; k++) begin
               r_valid[r_dst][r_cnt][k]  <= r_valid[r_src][r_cnt][k];
               r_target[r_dst][r_cnt][k] <= r_target[r_src][r_cnt][k];
            end
         end
         if (r_stg_valid) begin
            r_valid[r_stg_ctx][r_stg_row][r_stg_col]  <= 1'b1;
            r_target[r_stg_ctx][r_stg_row][r_stg_col] <= r_stg_tgt;
         end
      end
   end

   for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_pred
      assign pred_valid_o[i]                = r_valid[r_active_ctx][w_vpc_row][i];
      assign pred_target_o[i*VLEN +: VLEN]  = r_target[r_active_ctx][w_vpc_row][i];
   end

   assign active_ctx_o = r_active_ctx;
   assign clone_busy_o = w_busy;
   assign clone_done_o = w_done;
   assign clone_err_o  = w_err;

endmodule

// File: tb/tb_btb_ctx_bank.sv
// Scoreboard bench for btb_ctx_bank: a cycle-scheduled reference model predicts every
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_btb_ctx_bank;
   localparam int NR_CTX     = 4;
   localparam int NR_ENTRIES = 8;
   localparam int IPF        = 2;
   localparam int VLEN       = 39;
   localparam int CTX_W      = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_ni = 1'b0;
   logic                  flush_i = 1'b0;
   logic                  debug_mode_i = 1'b0;
   logic [CTX_W-1:0]      ctx_sel_i = '0;
   logic [CTX_W-1:0]      active_ctx_o;
   logic [VLEN-1:0]       vpc_i = '0;
   logic                  upd_valid_i = 1'b0;
   logic [VLEN-1:0]       upd_pc_i = '0;
   logic [VLEN-1:0]       upd_target_i = '0;
   logic [IPF-1:0]        pred_valid_o;
   logic [IPF*VLEN-1:0]   pred_target_o;
   logic                  clone_req_i = 1'b0;
   logic [CTX_W-1:0]      clone_src_i = '0;
   logic [CTX_W-1:0]      clone_dst_i = '0;
   logic                  clone_busy_o;
   logic                  clone_done_o;
   logic                  clone_err_o;

   btb_ctx_bank #(
      .NR_CTX(NR_CTX), .NR_ENTRIES(NR_ENTRIES), .INSTR_PER_FETCH(IPF), .VLEN(VLEN)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
      .ctx_sel_i(ctx_sel_i), .active_ctx_o(active_ctx_o), .vpc_i(vpc_i),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
      .pred_valid_o(pred_valid_o), .pred_target_o(pred_target_o),
      .clone_req_i(clone_req_i), .clone_src_i(clone_src_i), .clone_dst_i(clone_dst_i),
      .clone_busy_o(clone_busy_o), .clone_done_o(clone_done_o), .clone_err_o(clone_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [IPF-1:0]      pv;
      logic [IPF*VLEN-1:0] pt;
      logic [CTX_W-1:0]    act;
      logic                busy;
      logic                done;
      logic                err;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int               ctx;
      int               row;
      int               col;
      logic [VLEN-1:0]  tgt;
      int               due;
   } wr_t;
   wr_t pend_q[$];

   bit               m_valid [NR_CTX][NR_ENTRIES][IPF];
   logic [VLEN-1:0]  m_tgt   [NR_CTX][NR_ENTRIES][IPF];
   int               m_active = 0;
   int               cyc = 0;
   bit               cl_on = 0;
   int               cl_start = 0;
   int               cl_src = 0;
   int               cl_dst = 0;

   int n_checks = 0;
   int n_errors = 0;

   function automatic int row_of(input logic [VLEN-1:0] pc);
      longint unsigned p;
      p = 64'(pc);
      return int'((p / longint'(2 * IPF)) % longint'(NR_ENTRIES));
   endfunction

   function automatic int col_of(input logic [VLEN-1:0] pc);
      longint unsigned p;
      p = 64'(pc);
      return int'((p / 64'd2) % longint'(IPF));
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, got, expv);
      end
   endtask

   // Model one cycle from the current inputs, queue its expected outputs, then advance.
   task automatic tick();
      exp_t e;
      wr_t  w;
      int   r, k, s, a, b;
      bit   in_copy, idle, legal;
      r = row_of(vpc_i);
      for (int i = 0; i < IPF; i++) begin
         e.pv[i] = m_valid[m_active][r][i];
         e.pt[i*VLEN +: VLEN] = m_tgt[m_active][r][i];
      end
      e.act   = CTX_W'(m_active);
      in_copy = cl_on && (cyc > cl_start) && (cyc <= cl_start + NR_ENTRIES);
      idle    = !cl_on || (cyc > cl_start + NR_ENTRIES + 1);
      e.busy  = in_copy;
      e.done  = cl_on && (cyc == cl_start + NR_ENTRIES + 1);
      a = int'(clone_src_i);
      b = int'(clone_dst_i);
      legal   = (a != b) && (a < NR_CTX) && (b < NR_CTX);
      e.err   = idle && clone_req_i && !legal;
      exp_q.push_back(e);

      if (flush_i) begin
         for (int c = 0; c < NR_CTX; c++)
            for (int rr = 0; rr < NR_ENTRIES; rr++)
               for (int cc = 0; cc < IPF; cc++) m_valid[c][rr][cc] = 0;
         pend_q.delete();
         cl_on = 0;
      end else begin
         if (in_copy) begin
            k = cyc - cl_start - 1;
            for (int cc = 0; cc < IPF; cc++) begin
               m_valid[cl_dst][k][cc] = m_valid[cl_src][k][cc];
               m_tgt[cl_dst][k][cc]   = m_tgt[cl_src][k][cc];
            end
         end
         while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            w = pend_q.pop_front();
            m_valid[w.ctx][w.row][w.col] = 1;
            m_tgt[w.ctx][w.row][w.col]   = w.tgt;
         end
         if (upd_valid_i && !debug_mode_i) begin
            w.ctx = m_active; w.row = row_of(upd_pc_i); w.col = col_of(upd_pc_i);
            w.tgt = upd_target_i; w.due = cyc + 1;
            pend_q.push_back(w);
         end
         if (idle && clone_req_i && legal) begin
            cl_on = 1; cl_start = cyc; cl_src = a; cl_dst = b;
         end
      end
      s = int'(ctx_sel_i);
      if (s < NR_CTX) m_active = s;
      cyc++;
      @(posedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pred_valid", 64'(pred_valid_o), 64'(e.pv));
         for (int i = 0; i < IPF; i++)
            if (e.pv[i]) chk("pred_target", 64'(pred_target_o[i*VLEN +: VLEN]), 64'(e.pt[i*VLEN +: VLEN]));
         chk("active_ctx", 64'(active_ctx_o), 64'(e.act));
         chk("clone_busy", 64'(clone_busy_o), 64'(e.busy));
         chk("clone_done", 64'(clone_done_o), 64'(e.done));
         chk("clone_err",  64'(clone_err_o),  64'(e.err));
      end
   end

   task automatic quiet();
      flush_i = 0; debug_mode_i = 0; upd_valid_i = 0; clone_req_i = 0;
   endtask

   task automatic upd(input logic [VLEN-1:0] pc, input logic [VLEN-1:0] tgt);
      upd_valid_i = 1; upd_pc_i = pc; upd_target_i = tgt;
      tick();
      upd_valid_i = 0;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic scan(input int c);
      ctx_sel_i = CTX_W'(c);
      tick();
      for (int r = 0; r < NR_ENTRIES; r++) begin
         vpc_i = VLEN'(32'h1000 + r * 4);
         tick();
      end
   endtask

   task automatic clone(input int s, input int d);
      clone_req_i = 1; clone_src_i = CTX_W'(s); clone_dst_i = CTX_W'(d);
      tick();
      clone_req_i = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e0;
      e0.pv = '0; e0.pt = '0; e0.act = '0; e0.busy = 0; e0.done = 0; e0.err = 0;
      for (int c = 0; c < NR_CTX; c++)
         for (int r = 0; r < NR_ENTRIES; r++)
            for (int k = 0; k < IPF; k++) begin m_valid[c][r][k] = 0; m_tgt[c][r][k] = '0; end
      vpc_i = VLEN'(32'h1000);
      exp_q.push_back(e0);
      #12 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic hit in ctx 0: slot 1 of row 0 after two cycles.
      tick();
      upd(VLEN'(32'h1002), VLEN'(32'h2000));
      idle_n(3);

      // Context isolation.
      ctx_sel_i = 1; tick();
      upd(VLEN'(32'h1000), VLEN'(32'h3000));
      idle_n(2);
      ctx_sel_i = 2; idle_n(2);
      ctx_sel_i = 1; idle_n(2);

      // Switch right after capture: entry must land in ctx 1.
      upd(VLEN'(32'h1010), VLEN'(32'h4000));
      ctx_sel_i = 3; tick();
      vpc_i = VLEN'(32'h1010); idle_n(2);
      ctx_sel_i = 1; idle_n(2);

      // Populate ctx 1, then clone 1 -> 2 with a colliding update on row 3.
      for (int r = 0; r < NR_ENTRIES; r++)
         upd(VLEN'(32'h1000 + r * 4 + 2), VLEN'({$urandom(), $urandom()}));
      ctx_sel_i = 2; tick();
      clone(1, 2);
      clone_req_i = 1; clone_src_i = 0; clone_dst_i = 3; tick(); clone_req_i = 0;
      tick();
      upd(VLEN'(32'h100C), VLEN'(32'h5555));
      idle_n(8);
      scan(2);
      scan(1);

      // Illegal request.
      clone(1, 1);
      idle_n(2);

      // Flush on the fourth COPY cycle with an update in the stage.
      ctx_sel_i = 1; tick();
      clone(1, 3);
      idle_n(2);
      upd(VLEN'(32'h1004), VLEN'(32'h6666));
      flush_i = 1; tick(); flush_i = 0;
      idle_n(10);
      for (int c = 0; c < NR_CTX; c++) scan(c);

      // Debug mode suppresses updates.
      ctx_sel_i = 0; tick();
      debug_mode_i = 1; upd(VLEN'(32'h1004), VLEN'(32'h7777)); debug_mode_i = 0;
      idle_n(2);
      scan(0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         flush_i      = ($urandom_range(0, 99) < 2);
         debug_mode_i = ($urandom_range(0, 99) < 5);
         upd_valid_i  = 1'($urandom_range(0, 1));
         upd_pc_i     = VLEN'(32'h1000 + ($urandom_range(0, 31) << 1));
         upd_target_i = VLEN'({$urandom(), $urandom()});
         vpc_i        = VLEN'(32'h1000 + ($urandom_range(0, 15) << 1));
         ctx_sel_i    = CTX_W'($urandom_range(0, NR_CTX - 1));
         clone_req_i  = ($urandom_range(0, 19) == 0);
         clone_src_i  = CTX_W'($urandom_range(0, NR_CTX - 1));
         clone_dst_i  = CTX_W'($urandom_range(0, NR_CTX - 1));
         tick();
      end
      quiet();
      idle_n(12);
      for (int c = 0; c < NR_CTX; c++) scan(c);

      repeat (2) @(negedge clk_i);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/btb_ctx_bank.md
Name: btb_ctx_bank

Overview:
- Multi-context branch target buffer; successor to the two-bank checkpoint BTB scheme.
- Holds NR_CTX independent BTB contexts and serves predictions from the active one.
- Routes updates to the context that was active when the update arrived.
- Supports a context-clone engine that copies one context into another, one row per cycle.
- Sits in the frontend between the IF-stage PC and the branch-predict logic.

Parameters:
- NR_CTX, 4, number of predictor contexts (≥2). CTX_W = $clog2(NR_CTX).
- NR_ENTRIES, 8, rows per context (power of 2). ROW_W = $clog2(NR_ENTRIES).
- INSTR_PER_FETCH, 2, columns per row (power of 2). COL_W = $clog2(INSTR_PER_FETCH).
- VLEN, 39, virtual address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  invalidate all contexts
- debug_mode_i  in  1  suppress updates
- ctx_sel_i  in  CTX_W  requested active context
- active_ctx_o  out  CTX_W  registered active context
- vpc_i  in  VLEN  fetch PC
- upd_valid_i  in  1  update strobe
- upd_pc_i  in  VLEN  branch PC
- upd_target_i  in  VLEN  branch target
- pred_valid_o  out  INSTR_PER_FETCH  per-slot hit
- pred_target_o  out  INSTR_PER_FETCH*VLEN  per-slot target; slot i occupies bits [i*VLEN +: VLEN]
- clone_req_i  in  1  start clone
- clone_src_i  in  CTX_W  clone source context
- clone_dst_i  in  CTX_W  clone destination context
- clone_busy_o  out  1  clone in progress
- clone_done_o  out  1  one-cycle completion pulse
- clone_err_o  out  1  one-cycle illegal-request pulse

Behaviour:
- Reset:
  - All valid bits and targets in every context = 0.
  - active_ctx_q = 0; update stage empty; FSM = IDLE.
  - pred_valid_o = 0, pred_target_o = 0, clone_busy_o = clone_done_o = clone_err_o = 0.
- Indexing:
  - row = pc[ROW_W+COL_W : COL_W+1]; col = pc[COL_W:1].
  - Prediction slot i = {valid, target} at [active_ctx_q][row(vpc_i)][i]. Read is combinational from the array and registers.
- Context select:
  - active_ctx_q <= ctx_sel_i every cycle (1-cycle latency).
  - ctx_sel_i ≥ NR_CTX is ignored; active_ctx_q holds its value.
- Update pipeline:
  - upd_valid_i && !debug_mode_i && !flush_i in cycle t: stage register captures pc, target and ctx = active_ctx_q.
  - The array entry [ctx][row][col] is written (valid=1, target) at the end of t+1 and is visible on predictions in t+2.
  - A context switch between capture and write does not redirect the write.
- Flush:
  - flush_i in cycle t clears every valid bit in all contexts at the end of t.
  - It also empties the update stage.
  - It aborts any clone: FSM returns to IDLE with no done pulse. Targets need not be cleared.
  - Flush has priority over every write.
- Clone FSM, IDLE -> COPY -> DONE -> IDLE:
  - IDLE: on clone_req_i, with src != dst and both < NR_CTX, latch src/dst, set row counter = 0, go to COPY.
  - IDLE, illegal request: clone_err_o = 1 for one cycle; stay IDLE.
  - COPY: each cycle copy all columns (valid + target) of row cnt from src to dst; increment cnt. After row NR_ENTRIES-1, go to DONE. clone_busy_o = 1 in COPY only.
  - DONE: clone_done_o = 1 for one cycle, then IDLE.
  - clone_req_i outside IDLE is ignored, with no error.
  - Latency: request accepted in cycle t -> rows copied in t+1..t+NR_ENTRIES -> done pulse in t+NR_ENTRIES+1.
- Collisions:
  - A stage write and a clone copy to the same dst row/col in the same cycle: the stage write wins.
  - A stage write to a src entry in the same cycle it is copied: the copy takes the pre-write value.
  - Predictions and updates continue normally during a clone, including on src or dst.
- Width: row and col fields are truncations of the PC; no other arithmetic. Row counter width is ROW_W+1 or handled via terminal compare.

Test Plan:
- Reset then vpc_i=0x1000 -> pred_valid_o=2'b00 and active_ctx_o=0. Update pc=0x1002, target=0x2000 in ctx 0 -> at t+2 pred_valid_o=2'b10 and slot1 target=0x2000.
- Context isolation: write pc=0x1000 -> 0x3000 in ctx 1, then ctx_sel_i=2 -> one cycle later the vpc_i=0x1000 prediction misses. Return to ctx 1 -> hit with 0x3000.
- Update captured in ctx 1, then ctx_sel_i=3 the next cycle -> entry lands in ctx 1, ctx 3 untouched.
- Clone src=1, dst=2 with NR_ENTRIES=8:
  - busy for exactly 8 cycles, done pulse on cycle 9.
  - ctx 2 then mirrors ctx 1 on all rows.
  - An update to ctx 2 row 3 colliding with the copy of row 3 survives.
- Clone src=dst=1 -> clone_err_o single pulse, busy stays 0. clone_req_i during COPY is ignored.
- flush_i mid-clone (cycle 4 of COPY) together with a pending update -> all contexts miss, no done pulse, FSM IDLE, the pending update is not written. debug_mode_i=1 with upd_valid_i -> no entry written.
